// File: rtl/rect_interp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : rect_interp                                                  |
// | Description : Bilinear interpolator sweeping a left/right line pair out    |
// |               of a dual-line buffer, 1280 pixels per update.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module rect_interp (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enb,
  input  logic [3:0] frac_x,
  input  logic [3:0] frac_y,
  input  logic       rdy,
  input  logic       upd,
  output logic       lr_sel,
  output logic [9:0] rdaddr,
  input  logic [7:0] rddata_up,
  input  logic [7:0] rddata_lo,
  output logic       out_vld,
  output logic       out_lr,
  output logic [9:0] out_x,
  output logic [7:0] out_pix,
  output logic       out_last,
  output logic       busy,
  output logic       ovf
);

  localparam logic [9:0] C_LAST_X = 10'd639;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LEFT  = 2'd1,
    S_RIGHT = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t     state_q;
  logic [9:0] rdaddr_q;
  logic [3:0] fx_q, fy_q;
  logic       busy_q, ovf_q;

  // Stage 1: address issued last cycle, aligned with returning RAM data
  logic       s1_vld_q;
  logic [9:0] s1_x_q;
  logic       lr_sel_q;

  // Stage 2: vertical blend of column x
  logic        v2_vld_q, v2_side_q;
  logic [9:0]  v2_x_q;
  logic [11:0] v2_q;

  // Stage 3: previous vertical blend, paired with stage 2 as its right neighbour
  logic        v3_vld_q, v3_side_q;
  logic [9:0]  v3_x_q;
  logic [11:0] v3_q;

  // Output registers
  logic       out_vld_q, out_lr_q, out_last_q;
  logic [9:0] out_x_q;
  logic [7:0] out_pix_q;

  logic        issue_w, side_w;
  logic [4:0]  wy_lo_w, wy_up_w, wx_lo_w, wx_up_w;
  logic [11:0] v_w, vn_w;
  logic [16:0] h_w;
  logic [7:0]  pix_w;

  assign issue_w = (state_q == S_LEFT) || (state_q == S_RIGHT);
  assign side_w  = (state_q == S_RIGHT);

  assign wy_lo_w = {1'b0, fy_q};
  assign wy_up_w = 5'd16 - wy_lo_w;
  assign wx_lo_w = {1'b0, fx_q};
  assign wx_up_w = 5'd16 - wx_lo_w;

  // Weights sum to 16, so the 13-bit sum never exceeds 4080 and fits 12 bits
  assign v_w = 12'(13'(rddata_up) * 13'(wy_up_w) + 13'(rddata_lo) * 13'(wy_lo_w));

  // Column 639 replicates itself; this also keeps left and right sides apart
  assign vn_w = (v3_x_q == C_LAST_X) ? v3_q : v2_q;

  assign h_w   = 17'(v3_q) * 17'(wx_up_w) + 17'(vn_w) * 17'(wx_lo_w);
  // h <= 65280, so the rounded result is at most 255
  assign pix_w = 8'((h_w + 17'd128) >> 8);

  // Sweep sequencer: state, read address, captured weights, busy and overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdaddr_q <= '0;
      fx_q     <= '0;
      fy_q     <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (!enb) begin
      state_q  <= S_IDLE;
      rdaddr_q <= '0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (upd && rdy && (state_q != S_IDLE)) begin
        ovf_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          if (rdy && upd) begin
            state_q  <= S_LEFT;
            rdaddr_q <= '0;
            busy_q   <= 1'b1;
            fx_q     <= frac_x;
            fy_q     <= frac_y;
          end
        end
        S_LEFT: begin
          if (rdaddr_q == C_LAST_X) begin
            state_q  <= S_RIGHT;
            rdaddr_q <= '0;
          end else begin
            rdaddr_q <= rdaddr_q + 10'd1;
          end
        end
        S_RIGHT: begin
          if (rdaddr_q == C_LAST_X) begin
            state_q  <= S_DRAIN;
            rdaddr_q <= '0;
          end else begin
            rdaddr_q <= rdaddr_q + 10'd1;
          end
        end
        S_DRAIN: begin
          if (out_last_q) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // Track side/column of each issued address so they line up with read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_x_q   <= '0;
      lr_sel_q <= 1'b0;
    end else begin
      s1_vld_q <= enb && issue_w;
      if (issue_w) begin
        s1_x_q   <= rdaddr_q;
        lr_sel_q <= side_w;
      end
    end
  end

  // Vertical blend of the returned upper/lower pixels, then hold one column back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_vld_q  <= 1'b0;
      v2_side_q <= 1'b0;
      v2_x_q    <= '0;
      v2_q      <= '0;
      v3_vld_q  <= 1'b0;
      v3_side_q <= 1'b0;
      v3_x_q    <= '0;
      v3_q      <= '0;
    end else begin
      v2_vld_q <= enb && s1_vld_q;
      if (s1_vld_q) begin
        v2_side_q <= lr_sel_q;
        v2_x_q    <= s1_x_q;
        v2_q      <= v_w;
      end
      v3_vld_q <= enb && v2_vld_q;
      if (v2_vld_q) begin
        v3_side_q <= v2_side_q;
        v3_x_q    <= v2_x_q;
        v3_q      <= v2_q;
      end
    end
  end

  // Horizontal blend with rounding into the registered output pixel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_lr_q   <= 1'b0;
      out_x_q    <= '0;
      out_pix_q  <= '0;
    end else begin
      out_vld_q  <= enb && v3_vld_q;
      out_last_q <= enb && v3_vld_q && v3_side_q && (v3_x_q == C_LAST_X);
      if (v3_vld_q) begin
        out_lr_q  <= v3_side_q;
        out_x_q   <= v3_x_q;
        out_pix_q <= pix_w;
      end
    end
  end

  assign lr_sel   = lr_sel_q;
  assign rdaddr   = rdaddr_q;
  assign out_vld  = out_vld_q;
  assign out_lr   = out_lr_q;
  assign out_x    = out_x_q;
  assign out_pix  = out_pix_q;
  assign out_last = out_last_q;
  assign busy     = busy_q;
  assign ovf      = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_rect_interp.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_rect_interp                                               |
// | Description : Scoreboard bench for rect_interp with a line-buffer model.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_rect_interp;

  logic       clk = 1'b0;
  logic       rst_n, enb, rdy, upd;
  logic [3:0] frac_x, frac_y;
  logic       lr_sel;
  logic [9:0] rdaddr;
  logic [7:0] rddata_up, rddata_lo;
  logic       out_vld, out_lr, out_last, busy, ovf;
  logic [9:0] out_x;
  logic [7:0] out_pix;

  int total = 0;
  int bad   = 0;

  logic [7:0] up_m [2][640];
  logic [7:0] lo_m [2][640];
  logic [7:0] ram_up_l, ram_up_r, ram_lo_l, ram_lo_r;

  typedef struct packed {
    logic       lr;
    logic [9:0] x;
    logic [7:0] pix;
    logic       last;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  rect_interp dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enb       (enb),
    .frac_x    (frac_x),
    .frac_y    (frac_y),
    .rdy       (rdy),
    .upd       (upd),
    .lr_sel    (lr_sel),
    .rdaddr    (rdaddr),
    .rddata_up (rddata_up),
    .rddata_lo (rddata_lo),
    .out_vld   (out_vld),
    .out_lr    (out_lr),
    .out_x     (out_x),
    .out_pix   (out_pix),
    .out_last  (out_last),
    .busy      (busy),
    .ovf       (ovf)
  );

  // Line buffer: both sides read at rdaddr, side mux after the RAM
  always @(posedge clk) begin
    ram_up_l <= up_m[0][rdaddr];
    ram_up_r <= up_m[1][rdaddr];
    ram_lo_l <= lo_m[0][rdaddr];
    ram_lo_r <= lo_m[1][rdaddr];
  end
  assign rddata_up = lr_sel ? ram_up_r : ram_up_l;
  assign rddata_lo = lr_sel ? ram_lo_r : ram_lo_l;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_lr_sel"},   32'(lr_sel),   0);
    chk({tag, "_rdaddr"},   32'(rdaddr),   0);
    chk({tag, "_out_vld"},  32'(out_vld),  0);
    chk({tag, "_out_lr"},   32'(out_lr),   0);
    chk({tag, "_out_x"},    32'(out_x),    0);
    chk({tag, "_out_pix"},  32'(out_pix),  0);
    chk({tag, "_out_last"}, 32'(out_last), 0);
    chk({tag, "_busy"},     32'(busy),     0);
    chk({tag, "_ovf"},      32'(ovf),      0);
  endtask

  function automatic int vblend(int s, int x, int fy);
    return int'(up_m[s][x]) * (16 - fy) + int'(lo_m[s][x]) * fy;
  endfunction

  function automatic int hpix(int s, int x, int fx, int fy);
    int xn;
    int h;
    xn = (x == 639) ? 639 : x + 1;
    h  = vblend(s, x, fy) * (16 - fx) + vblend(s, xn, fy) * fx;
    return (h + 128) / 256;
  endfunction

  task automatic push_all(input int fx, input int fy);
    exp_t e;
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 640; x++) begin
        e.lr   = 1'(s);
        e.x    = 10'(x);
        e.pix  = 8'(hpix(s, x, fx, fy));
        e.last = (s == 1) && (x == 639);
        sb.push_back(e);
      end
    end
  endtask

  task automatic fill_random();
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 640; x++) begin
        up_m[s][x] = 8'($urandom);
        lo_m[s][x] = 8'($urandom);
      end
    end
  endtask

  // One line-pair sweep started at cycle 0; optional second upd, abort or reset
  task automatic sweep(input int fx, input int fy, input int upd2_at,
                       input int abort_at, input int reset_at);
    int first_vld;
    int last_cyc;
    int busy_low;
    int exp_low;
    bit live;
    first_vld = -1;
    last_cyc  = -1;
    busy_low  = -1;
    live      = 1'b1;
    @(posedge clk); #1; enb = 1'b0;
    @(posedge clk); #1; enb = 1'b1;
    push_all(fx, fy);
    @(posedge clk); #1;
    frac_x = 4'(fx); frac_y = 4'(fy); rdy = 1'b1; upd = 1'b1;
    for (int c = 1; c <= 1300; c++) begin
      @(posedge clk); #1;
      if (live && out_vld && first_vld < 0) first_vld = c;
      if (out_last) last_cyc = c;
      if (!busy && busy_low < 0) busy_low = c;
      if (live) begin
        if (c == 1)   begin chk("start_busy", 32'(busy), 1); chk("start_addr", 32'(rdaddr), 0); end
        if (c == 2)   chk("addr_step", 32'(rdaddr), 1);
        if (c == 641) begin chk("right_addr0", 32'(rdaddr), 0); chk("lr_sel_left", 32'(lr_sel), 0); end
        if (c == 642) chk("lr_sel_right", 32'(lr_sel), 1);
      end
      if (upd2_at >= 0 && c == upd2_at)     chk("ovf_before", 32'(ovf), 0);
      if (upd2_at >= 0 && c == upd2_at + 1) chk("ovf_set", 32'(ovf), 1);
      if (abort_at >= 0 && c == abort_at + 1) begin
        chk("abort_vld",    32'(out_vld),  0);
        chk("abort_last",   32'(out_last), 0);
        chk("abort_busy",   32'(busy),     0);
        chk("abort_ovf",    32'(ovf),      0);
        chk("abort_addr",   32'(rdaddr),   0);
        chk("abort_q_left", 32'(sb.size()), 32'(1280 - (abort_at - 4)));
        sb.delete();
        live = 1'b0;
      end
      // drive inputs for cycle c
      upd    = (c == upd2_at);
      enb    = (c != abort_at);
      frac_x = 4'($urandom);
      frac_y = 4'($urandom);
      if (reset_at >= 0 && c == reset_at) begin
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
        sb.delete();
        live = 1'b0;
      end
      if (reset_at >= 0 && c == reset_at + 3) rst_n = 1'b1;
    end
    upd = 1'b0;
    exp_low = (abort_at >= 0) ? abort_at + 1 : (reset_at >= 0) ? reset_at + 1 : 1285;
    chk("busy_low_cyc", 32'(busy_low), 32'(exp_low));
    chk("first_vld_cyc", 32'(first_vld), 5);
    if (abort_at < 0 && reset_at < 0) chk("last_cyc", 32'(last_cyc), 1284);
    chk("sb_empty", 32'(sb.size()), 0);
    chk("busy_end", 32'(busy), 0);
  endtask

  // Scoreboard: every strobe must match the next expected pixel
  always @(negedge clk) begin
    if (rst_n && out_vld) begin
      chk("strobe_expected", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("out_lr",   32'(out_lr),   32'(mon_e.lr));
        chk("out_x",    32'(out_x),    32'(mon_e.x));
        chk("out_pix",  32'(out_pix),  32'(mon_e.pix));
        chk("out_last", 32'(out_last), 32'(mon_e.last));
      end
    end
    if (rst_n && out_last && !out_vld) chk("last_needs_vld", 32'(out_vld), 1);
  end

  initial begin
    rst_n = 1'b0; enb = 1'b0; rdy = 1'b0; upd = 1'b0;
    frac_x = '0; frac_y = '0;
    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;

    // upd without rdy: no sweep, no overflow
    enb = 1'b1;
    @(posedge clk); #1; upd = 1'b1;
    @(posedge clk); #1; upd = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("nordy_busy", 32'(busy),    0);
    chk("nordy_ovf",  32'(ovf),     0);
    chk("nordy_addr", 32'(rdaddr),  0);
    chk("nordy_vld",  32'(out_vld), 0);

    // Identity: fx = fy = 0 reproduces the upper line
    fill_random();
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 640; x++) up_m[s][x] = 8'(x & 255);
    sweep(0, 0, -1, -1, -1);

    // Vertical half blend: 0 and 200 -> 100
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 640; x++) begin up_m[s][x] = 8'd0; lo_m[s][x] = 8'd200; end
    sweep(0, 8, -1, -1, -1);

    // Horizontal half blend on a ramp; upd during the out_last cycle
    fill_random();
    for (int s = 0; s < 2; s++)
      for (int x = 0; x < 128; x++) up_m[s][x] = 8'(2 * x);
    sweep(8, 0, 1284, -1, -1);

    // Edge replicate and no crossing between sides
    fill_random();
    for (int s = 0; s < 2; s++) begin up_m[s][638] = 8'd0; up_m[s][639] = 8'd255; end
    up_m[1][0] = 8'd0;
    sweep(15, 0, -1, -1, -1);

    // Random weights, overflow at 300, abort at 700
    fill_random();
    sweep(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)), 300, 700, -1);

    // Random weights, overflow at 100, asynchronous reset at 400
    fill_random();
    sweep(int'($urandom_range(1, 15)), int'($urandom_range(1, 15)), 100, -1, 400);

    repeat (5) @(posedge clk);
    #1 chk("final_sb_empty", 32'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
